// File: rtl/display_pkg.sv
// Shared types and constants for the 4-digit multiplexed display driver.
package display_pkg;

  localparam int NDIG  = 4;
  localparam int BIN_W = 14;
  localparam int BCD_W = 4 * NDIG;

  localparam logic [BIN_W-1:0] BCD_MAX    = BIN_W'(9999);
  localparam logic [3:0]       BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_e;

  // Marks every digit above the most significant nonzero one; units is never marked.
  function automatic logic [NDIG-1:0] lead_zero_mask(input logic [BCD_W-1:0] digits);
    logic lead;
    lead_zero_mask = '0;
    lead           = 1'b1;
    for (int i = NDIG - 1; i > 0; i--) begin
      lead              = lead && (digits[4*i +: 4] == 4'd0);
      lead_zero_mask[i] = lead;
    end
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per clock.
module bin2bcd_seq
  import display_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [BCD_W-1:0] bcd_o
);

  localparam logic [3:0] SHIFTS = 4'(BIN_W);

  logic [BIN_W-1:0] bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] adj_d;
  logic [3:0]       cnt_q;
  logic             busy_q;
  logic             done_q;

  always_comb begin
    adj_d = bcd_q;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i && !busy_q) begin
        bin_q  <= bin_i;
        bcd_q  <= '0;
        cnt_q  <= SHIFTS;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        bcd_q <= {adj_d[BCD_W-2:0], bin_q[BIN_W-1]};
        bin_q <= {bin_q[BIN_W-2:0], 1'b0};
        cnt_q <= cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/display_scan_driver.sv
// Binary-to-BCD conversion front end plus continuous 4-digit multiplexed scan.
// Optional DISPLAY_LEADING_ZERO_BLANK_EN blanks leading zero digits (units always shown).
//
//   state     | meaning
//   ST_IDLE   | in_ready=1, waiting for in_valid
//   ST_SHIFT  | bin2bcd_seq running; displayed digits unchanged
//   ST_COMMIT | digits/ovf just loaded, conv_done=1 for this cycle
module display_scan_driver
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BIN_W-1:0] in_bin,
  output logic             conv_done,
  output logic             ovf,
  output logic [3:0]       bcd,
  output logic [3:0]       an_n
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(REFRESH_DIV - 1);

  conv_state_e      state_q;
  logic [BIN_W-1:0] val_q;
  logic             in_ready_q;
  logic             conv_done_q;
  logic             ovf_q, ovf_d;
  logic [BCD_W-1:0] digits_q, digits_d;
  logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       bcd_q, bcd_d;
  logic [3:0]       an_n_q, an_n_d;
  logic [NDIG-1:0]  blank_d;

  logic             accept;
  logic             commit;
  logic             eng_busy;
  logic             eng_done;
  logic [BCD_W-1:0] eng_bcd;

  assign accept = in_valid && in_ready_q;
  assign commit = (state_q == ST_SHIFT) && eng_done && !eng_busy;

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (accept),
    .bin_i   (in_bin),
    .busy_o  (eng_busy),
    .done_o  (eng_done),
    .bcd_o   (eng_bcd)
  );

  // Next display contents are shared by the FSM and the scan so a commit shows on its own edge.
  always_comb begin
    ovf_d    = ovf_q;
    digits_d = digits_q;
    if (commit) begin
      ovf_d    = (val_q > BCD_MAX);
      digits_d = ovf_d ? {NDIG{BLANK_CODE}} : eng_bcd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      val_q       <= '0;
      in_ready_q  <= 1'b1;
      conv_done_q <= 1'b0;
      ovf_q       <= 1'b0;
      digits_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            val_q      <= in_bin;
            in_ready_q <= 1'b0;
            state_q    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (commit) begin
            ovf_q       <= ovf_d;
            digits_q    <= digits_d;
            conv_done_q <= 1'b1;
            state_q     <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          conv_done_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: begin
          conv_done_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 2'd1;
    end
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
    blank_d = lead_zero_mask(digits_d);
`else
    blank_d = '0;
`endif
    bcd_d  = blank_d[idx_d] ? BLANK_CODE : digits_d[{idx_d, 2'b00} +: 4];
    an_n_d = ~(4'b0001 << idx_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
      bcd_q      <= 4'h0;
      an_n_q     <= 4'b1110;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      bcd_q      <= bcd_d;
      an_n_q     <= an_n_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign conv_done = conv_done_q;
  assign ovf       = ovf_q;
  assign bcd       = bcd_q;
  assign an_n      = an_n_q;

endmodule
